// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter measurement path.
package freq_meter_pkg;

    localparam int unsigned BCD_W   = 16;
    localparam int unsigned STATE_W = 2;

    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

    localparam logic RANGE_NARROW = 1'b0;
    localparam logic RANGE_WIDE   = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        S_CLEAR  = 2'd0,
        S_GATE   = 2'd1,
        S_SETTLE = 2'd2,
        S_DECIDE = 2'd3
    } state_e;

    // True when the leading BCD digit is zero, i.e. the count is below 1000.
    function automatic logic bcd_below_1000(input logic [BCD_W-1:0] v);
        return (v[BCD_W-1 -: 4] == 4'd0);
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with a zero flag; times both the gate and settle phases.
module gate_timer #(
    parameter int unsigned TW = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/freq_range_ctrl.sv
// Gate/clear/latch sequencer for the BCD event counter with auto-ranging divider select.
// Optional FREQ_RANGE_CTRL_HOLD_EN adds a 'hold' input that freezes the displayed result.
module freq_range_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 100_000_000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TW            = 27
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FREQ_RANGE_CTRL_HOLD_EN
    input  logic             hold,
`endif
    input  logic             auto,
    input  logic             manual_range,
    input  logic [BCD_W-1:0] cnt_value,
    input  logic             cnt_ovf,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             range,
    output logic [BCD_W-1:0] result,
    output logic             result_range,
    output logic             over_range,
    output logic             result_valid
);

    state_e           state_q;
    state_e           state_d;

    logic             range_q;
    logic             range_d;
    logic             ovf_seen_q;
    logic             ovf_seen_d;
    logic [BCD_W-1:0] result_q;
    logic [BCD_W-1:0] result_d;
    logic             result_range_q;
    logic             result_range_d;
    logic             over_range_q;
    logic             over_range_d;
    logic             result_valid_q;
    logic             result_valid_d;
    logic             cnt_en_q;
    logic             cnt_en_d;

    logic             tmr_load_c;
    logic [TW-1:0]    tmr_val_c;
    logic             tmr_zero;
    logic             hold_c;

`ifdef FREQ_RANGE_CTRL_HOLD_EN
    assign hold_c = hold;
`else
    assign hold_c = 1'b0;
`endif

    gate_timer #(
        .TW(TW)
    ) u_gate_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .zero_o     (tmr_zero)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_CLEAR;
            range_q        <= RANGE_NARROW;
            ovf_seen_q     <= 1'b0;
            result_q       <= '0;
            result_range_q <= RANGE_NARROW;
            over_range_q   <= 1'b0;
            result_valid_q <= 1'b0;
            cnt_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            range_q        <= range_d;
            ovf_seen_q     <= ovf_seen_d;
            result_q       <= result_d;
            result_range_q <= result_range_d;
            over_range_q   <= over_range_d;
            result_valid_q <= result_valid_d;
            cnt_en_q       <= cnt_en_d;
        end
    end

    // Next-state logic: the timer zero flag ends the gate and settle phases.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR:  state_d = S_GATE;
            S_GATE:   if (tmr_zero) state_d = S_SETTLE;
            S_SETTLE: if (tmr_zero) state_d = S_DECIDE;
            S_DECIDE: state_d = S_CLEAR;
            default:  state_d = S_CLEAR;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        tmr_load_c     = 1'b0;
        tmr_val_c      = '0;
        range_d        = range_q;
        ovf_seen_d     = ovf_seen_q;
        result_d       = result_q;
        result_range_d = result_range_q;
        over_range_d   = over_range_q;
        result_valid_d = 1'b0;
        cnt_en_d       = (state_d == S_GATE);

        unique case (state_q)
            S_CLEAR: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TW'(GATE_CYCLES - 1);
                ovf_seen_d = 1'b0;
                if (!auto) begin
                    range_d = manual_range;
                end
            end
            S_GATE: begin
                if (cnt_ovf) begin
                    ovf_seen_d = 1'b1;
                end
                if (tmr_zero) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TW'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                // Late ripple from the counter still counts as an overflow.
                if (cnt_ovf) begin
                    ovf_seen_d = 1'b1;
                end
            end
            S_DECIDE: begin
                if (auto && ovf_seen_q && (range_q == RANGE_NARROW)) begin
                    range_d = RANGE_WIDE;
                end else if (auto && !ovf_seen_q && (range_q == RANGE_WIDE) &&
                             bcd_below_1000(cnt_value)) begin
                    range_d = RANGE_NARROW;
                end else if (!hold_c) begin
                    result_d       = cnt_value;
                    result_range_d = range_q;
                    over_range_d   = ovf_seen_q;
                    result_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Clear is a decode of the state flops, held off while reset is asserted.
    assign cnt_clr      = (state_q == S_CLEAR) && !reset;
    assign cnt_en       = cnt_en_q;
    assign range        = range_q;
    assign result       = result_q;
    assign result_range = result_range_q;
    assign over_range   = over_range_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_freq_range_ctrl.sv
// Self-checking bench for freq_range_ctrl with a per-measurement reference model.
module tb_freq_range_ctrl;

    localparam int unsigned G = 20;
    localparam int unsigned S = 4;
    localparam int P = 2 + G + S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        auto_s = 1'b0;
    logic        manual_range = 1'b0;
    logic [15:0] cnt_value = 16'h0000;
    logic        cnt_ovf = 1'b0;
`ifdef FREQ_RANGE_CTRL_HOLD_EN
    logic        hold = 1'b0;
`endif
    logic        cnt_clr;
    logic        cnt_en;
    logic        range_o;
    logic [15:0] result;
    logic        result_range;
    logic        over_range;
    logic        result_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid = 0;

    // Reference model state: what the display and divider should show.
    logic        exp_range = 1'b0;
    logic [15:0] exp_result = 16'h0000;
    logic        exp_rr = 1'b0;
    logic        exp_over = 1'b0;
    logic        pend = 1'b0;

    always #5 clk = ~clk;

    freq_range_ctrl #(
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (S),
        .TW            (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FREQ_RANGE_CTRL_HOLD_EN
        .hold         (hold),
`endif
        .auto         (auto_s),
        .manual_range (manual_range),
        .cnt_value    (cnt_value),
        .cnt_ovf      (cnt_ovf),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .range        (range_o),
        .result       (result),
        .result_range (result_range),
        .over_range   (over_range),
        .result_valid (result_valid)
    );

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // One full measurement starting at S_CLEAR; c indexes the cycle within the period.
    task automatic run_period(input logic auto_v, input logic [15:0] val, input int ovf_a,
                              input int ovf_b, input int man_cycle, input logic man_v,
                              input logic hold_v);
        logic seen;
        logic hold_eff;
        seen = 1'b0;
`ifdef FREQ_RANGE_CTRL_HOLD_EN
        hold_eff = hold_v;
`else
        hold_eff = 1'b0;
`endif
        for (int c = 0; c < P; c++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            if (c == 0) auto_s = auto_v;
            cnt_value = val;
            cnt_ovf = (c == ovf_a) || (c == ovf_b);
            if (c == man_cycle) manual_range = man_v;
`ifdef FREQ_RANGE_CTRL_HOLD_EN
            hold = hold_v;
`endif
            if (cnt_ovf && c >= 1 && c <= int'(G + S)) seen = 1'b1;
            cyc++;
            @(negedge clk);
            if (result_valid === 1'b1 && first_valid == 0) first_valid = cyc;
            checks += 7;
            if (cnt_clr !== (c == 0)) begin
                errors++; $display("FAIL cnt_clr c=%0d got %b exp %b", c, cnt_clr, c == 0);
            end
            if (cnt_en !== (c >= 1 && c <= int'(G))) begin
                errors++; $display("FAIL cnt_en c=%0d got %b", c, cnt_en);
            end
            if (range_o !== exp_range) begin
                errors++; $display("FAIL range c=%0d got %b exp %b", c, range_o, exp_range);
            end
            if (result_valid !== (c == 0 && pend)) begin
                errors++; $display("FAIL result_valid c=%0d got %b exp %b", c, result_valid, c == 0 && pend);
            end
            if (result !== exp_result) begin
                errors++; $display("FAIL result c=%0d got %h exp %h", c, result, exp_result);
            end
            if (result_range !== exp_rr) begin
                errors++; $display("FAIL result_range c=%0d got %b exp %b", c, result_range, exp_rr);
            end
            if (over_range !== exp_over) begin
                errors++; $display("FAIL over_range c=%0d got %b exp %b", c, over_range, exp_over);
            end
            if (c == 0) begin
                pend = 1'b0;
                if (!auto_s) exp_range = manual_range;
            end
            if (c == P - 1) begin
                if (auto_s && seen && !exp_range) begin
                    exp_range = 1'b1;
                end else if (auto_s && !seen && exp_range && val < 16'h1000) begin
                    exp_range = 1'b0;
                end else if (!hold_eff) begin
                    exp_result = val;
                    exp_rr     = exp_range;
                    exp_over   = seen;
                    pend       = 1'b1;
                end
            end
        end
        cnt_ovf = 1'b0;
    endtask

    task automatic model_reset();
        exp_range = 1'b0; exp_result = 16'h0000; exp_rr = 1'b0; exp_over = 1'b0; pend = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt_clr, cnt_en, range_o, result, result_range, over_range, result_valid} !== 22'd0) begin
                errors++;
                $display("FAIL reset_values got clr=%b en=%b rng=%b res=%h rr=%b ovr=%b v=%b exp all 0",
                         cnt_clr, cnt_en, range_o, result, result_range, over_range, result_valid);
            end
        end
        model_reset();
        cyc = 0;
        first_valid = 0;
    endtask

    task automatic test_first_measurement();
        run_period(1'b1, 16'h0456, -1, -1, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h0456, -1, -1, -1, 1'b0, 1'b0);
        checks++;
        if (first_valid != 27) begin
            errors++; $display("FAIL first_valid_cycle got %0d exp 27", first_valid);
        end
    endtask

    task automatic test_uprange();
        run_period(1'b1, 16'h0000, 10, -1, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h1234, -1, -1, -1, 1'b0, 1'b0);
        checks++;
        if (exp_range !== 1'b1 || exp_result !== 16'h1234) begin
            errors++; $display("FAIL uprange_model got rng=%b res=%h exp 1 1234", exp_range, exp_result);
        end
    endtask

    task automatic test_downrange();
        run_period(1'b1, 16'h0999, -1, -1, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h0000, 5, -1, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h1000, -1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_over_range();
        run_period(1'b1, 16'h0042, int'(G), int'(G) + 2, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h0042, 0, P - 1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_manual();
        run_period(1'b0, 16'h0777, 5, -1, 10, 1'b1, 1'b0);
        run_period(1'b0, 16'h0123, 12, -1, -1, 1'b0, 1'b0);
        run_period(1'b0, 16'h0321, -1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_gate();
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            reset = (c == 7);
            cnt_value = 16'h0888;
            cnt_ovf = 1'b0;
            @(negedge clk);
            checks++;
            if (cnt_en !== (c >= 1)) begin
                errors++; $display("FAIL midgate_en c=%0d got %b", c, cnt_en);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 4;
        if (cnt_en !== 1'b0) begin errors++; $display("FAIL midgate_reset_en got %b exp 0", cnt_en); end
        if (range_o !== 1'b0) begin errors++; $display("FAIL midgate_reset_range got %b exp 0", range_o); end
        if (result !== 16'h0000) begin errors++; $display("FAIL midgate_reset_result got %h exp 0000", result); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL midgate_reset_valid got %b exp 0", result_valid); end
        model_reset();
    endtask

    task automatic test_hold();
        run_period(1'b1, 16'h1111, -1, -1, -1, 1'b0, 1'b1);
        run_period(1'b1, 16'h0000, 8, -1, -1, 1'b0, 1'b1);
        run_period(1'b1, 16'h2222, -1, -1, -1, 1'b0, 1'b1);
        run_period(1'b1, 16'h3333, -1, -1, -1, 1'b0, 1'b0);
        run_period(1'b1, 16'h3333, -1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int oa, ob, mc;
            oa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, P - 1) : -1;
            ob = ($urandom_range(0, 3) == 0) ? $urandom_range(0, P - 1) : -1;
            mc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, P - 1) : -1;
            run_period(1'($urandom_range(0, 3) != 0), rand_bcd(), oa, ob, mc,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_first_measurement();
        test_uprange();
        test_downrange();
        test_over_range();
        test_manual();
        test_reset_mid_gate();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
